// File: rtl/sm_trace_buffer.sv
// Execution-trace capture buffer for sm_cpu: circular {pc,instr,stamp} log with
// PC trigger + post window, step watchdog, and oldest-first registered readout.
// Ports: clk, rst (sync, active high), stepEn/pc/instr (CPU step), arm, trigEn,
//   trigPc, rdIdx -> rdPc/rdInstr/rdCycle (1-cycle latency), count, busy, done,
//   trigHit, timeout.
module sm_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int CYC_W      = 16,
  parameter int POST_TRIG  = 8,
  parameter int STEP_LIMIT = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stepEn,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             arm,
  input  logic             trigEn,
  input  logic [31:0]      trigPc,
  input  logic [AW-1:0]    rdIdx,
  output logic [31:0]      rdPc,
  output logic [31:0]      rdInstr,
  output logic [CYC_W-1:0] rdCycle,
  output logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic             trigHit,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]      FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    POST_LAST = AW'(POST_TRIG - 1);
  localparam logic [CYC_W-1:0] STEP_LAST = CYC_W'(STEP_LIMIT - 1);
  localparam bit               WD_EN     = (STEP_LIMIT != 0);
  localparam bit               NO_POST   = (POST_TRIG == 0);

  state_t state, state_nx;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    post_cnt;
  logic [CYC_W-1:0] step_cnt;
  logic [AW-1:0]    rd_addr;

  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [CYC_W-1:0] mem_cyc   [DEPTH];

  logic capturing;
  logic cap;
  logic hit;
  logic wd;
  logic post_end;

  // arm wins over a same-cycle step: that step is dropped
  assign capturing = (state == ARMED) || (state == POST);
  assign cap       = stepEn && capturing && !arm;
  assign hit       = cap && (state == ARMED) && trigEn && (pc == trigPc);
  assign wd        = cap && WD_EN && (step_cnt == STEP_LAST);
  assign post_end  = cap && (state == POST) && (post_cnt == POST_LAST);

  // once full, the oldest entry sits at the write pointer
  assign rd_addr = (count < FULL) ? rdIdx : wr_ptr + rdIdx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = ARMED;
    end else begin
      unique case (state)
        IDLE:  state_nx = IDLE;
        ARMED: begin
          if (wd)       state_nx = DONE;
          else if (hit) state_nx = NO_POST ? DONE : POST;
        end
        POST:  begin
          if (wd || post_end) state_nx = DONE;
        end
        DONE:  state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ARMED, POST: busy = 1'b1;
      DONE:        done = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      wr_ptr   <= '0;
      count    <= '0;
      step_cnt <= '0;
      post_cnt <= '0;
      trigHit  <= 1'b0;
      timeout  <= 1'b0;
    end else if (cap) begin
      wr_ptr   <= wr_ptr + 1'b1;
      step_cnt <= step_cnt + 1'b1;
      if (count != FULL)   count    <= count + 1'b1;
      if (state == POST)   post_cnt <= post_cnt + 1'b1;
      if (hit)             trigHit  <= 1'b1;
      if (wd)              timeout  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= instr;
      mem_cyc[wr_ptr]   <= step_cnt;
    end
  end

  // an empty buffer reads back as zero rather than uninitialised storage
  always_ff @(posedge clk) begin
    if (rst || count == '0) begin
      rdPc    <= '0;
      rdInstr <= '0;
      rdCycle <= '0;
    end else begin
      rdPc    <= mem_pc[rd_addr];
      rdInstr <= mem_instr[rd_addr];
      rdCycle <= mem_cyc[rd_addr];
    end
  end

endmodule
